// File: rtl/keypad_if.sv
// Keypad matrix lines plus the accepted-key outputs of keypad_scanner.
// The scanner takes the master modport; the consumer of key codes takes slave.
interface keypad_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with whole-scan debounce and hex encoding.
// Define KEYPAD_REPEAT_EN to add auto-repeat of key_valid while a key is held.
module keypad_scanner #(
  parameter int CLK_PER_COL        = 100_000,
  parameter int DEBOUNCE_SCANS     = 4,
  parameter int REPEAT_DELAY_SCANS = 125,
  parameter int REPEAT_RATE_SCANS  = 25
) (
  input  logic     clk,
  input  logic     reset,
  keypad_if.master kp
);

  localparam int TW = (CLK_PER_COL > 1) ? $clog2(CLK_PER_COL) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_PER_COL - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;

  logic [3:0]    rs_meta, rs;
  logic [TW-1:0] tick;
  logic [1:0]    c;
  logic [15:0]   image;
  logic          scan_done;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    cand;
  logic [1:0]    ones;
  logic [3:0]    hit_idx;
  logic [3:0]    hit_code;
  logic          hit_none, hit_single;

  // Image bit 4*c+r corresponds to row r of column c.
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    case (idx)
      4'd0:  key_map = 4'h1;  4'd1:  key_map = 4'h4;
      4'd2:  key_map = 4'h7;  4'd3:  key_map = 4'h0;
      4'd4:  key_map = 4'h2;  4'd5:  key_map = 4'h5;
      4'd6:  key_map = 4'h8;  4'd7:  key_map = 4'hF;
      4'd8:  key_map = 4'h3;  4'd9:  key_map = 4'h6;
      4'd10: key_map = 4'h9;  4'd11: key_map = 4'hE;
      4'd12: key_map = 4'hA;  4'd13: key_map = 4'hB;
      4'd14: key_map = 4'hC;  default: key_map = 4'hD;
    endcase
  endfunction

  assign kp.col = ~(4'b0001 << c);

  // Rows are sampled at the last tick of a column, long after the 2-flop sync settles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_meta   <= '1;
      rs        <= '1;
      tick      <= '0;
      c         <= '0;
      image     <= '0;
      scan_done <= 1'b0;
    end else begin
      rs_meta   <= kp.row;
      rs        <= rs_meta;
      scan_done <= (tick == TICK_LAST) && (c == 2'd3);
      if (tick == TICK_LAST) begin
        tick                  <= '0;
        image[{c, 2'b00} +: 4] <= ~rs;
        c                     <= c + 2'd1;
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

  always_comb begin
    ones    = '0;
    hit_idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (image[i]) begin
        if (ones != 2'd2) ones = ones + 2'd1;
        hit_idx = 4'(i);
      end
    end
    hit_none   = (ones == 2'd0);
    hit_single = (ones == 2'd1);
    hit_code   = key_map(hit_idx);
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ?
                        REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_SCANS - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_SCANS - 1);
  logic [RW-1:0] rep_cnt;
  logic          rep_rate;
`else
  localparam int unused_repeat = REPEAT_DELAY_SCANS + REPEAT_RATE_SCANS;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      cand         <= '0;
      kp.key_code  <= '0;
      kp.key_valid <= 1'b0;
      kp.key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt      <= '0;
      rep_rate     <= 1'b0;
`endif
    end else begin
      kp.key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      // Repeat state only lives across PRESSED/DEB_RELEASE; any other state clears it.
      if (state == IDLE || state == DEB_PRESS) begin
        rep_cnt  <= '0;
        rep_rate <= 1'b0;
      end
`endif
      if (scan_done) begin
        case (state)
          IDLE: begin
            if (hit_single) begin
              cand <= hit_code;
              if (DEBOUNCE_SCANS == 1) begin
                kp.key_code  <= hit_code;
                kp.key_valid <= 1'b1;
                kp.key_held  <= 1'b1;
                cnt          <= '0;
                state        <= PRESSED;
              end else begin
                cnt   <= CW'(1);
                state <= DEB_PRESS;
              end
            end
          end
          DEB_PRESS: begin
            if (hit_single && hit_code == cand) begin
              if (cnt == DEB_LAST) begin
                kp.key_code  <= cand;
                kp.key_valid <= 1'b1;
                kp.key_held  <= 1'b1;
                cnt          <= '0;
                state        <= PRESSED;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else if (hit_single) begin
              cand <= hit_code;
              cnt  <= CW'(1);
            end else begin
              cnt   <= '0;
              state <= IDLE;
            end
          end
          PRESSED: begin
            if (hit_none) begin
              if (DEBOUNCE_SCANS == 1) begin
                kp.key_held <= 1'b0;
                cnt         <= '0;
                state       <= IDLE;
              end else begin
                cnt   <= CW'(1);
                state <= DEB_RELEASE;
              end
            end else begin
`ifdef KEYPAD_REPEAT_EN
              if ((!rep_rate && rep_cnt == DELAY_LAST) ||
                  (rep_rate && rep_cnt == RATE_LAST)) begin
                kp.key_valid <= 1'b1;
                rep_cnt      <= '0;
                rep_rate     <= 1'b1;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
`endif
            end
          end
          DEB_RELEASE: begin
            if (hit_none) begin
              if (cnt == DEB_LAST) begin
                kp.key_held <= 1'b0;
                cnt         <= '0;
                state       <= IDLE;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              cnt   <= '0;
              state <= PRESSED;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
